// File: rtl/decm.sv
// rtl/decm.sv - RV32I instruction decode stage with registered valid/ready output.
// Define ECAP5_DPROC_DECM_SKID_EN to add a skid register that isolates input_ready_o from output_ready_i.
module decm (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [3:0]  opclass_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  funct3_o,
    output logic        alt_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    localparam logic [3:0] OPC_LUI      = 4'd0;
    localparam logic [3:0] OPC_AUIPC    = 4'd1;
    localparam logic [3:0] OPC_JAL      = 4'd2;
    localparam logic [3:0] OPC_JALR     = 4'd3;
    localparam logic [3:0] OPC_BRANCH   = 4'd4;
    localparam logic [3:0] OPC_LOAD     = 4'd5;
    localparam logic [3:0] OPC_STORE    = 4'd6;
    localparam logic [3:0] OPC_OP_IMM   = 4'd7;
    localparam logic [3:0] OPC_OP       = 4'd8;
    localparam logic [3:0] OPC_MISC_MEM = 4'd9;
    localparam logic [3:0] OPC_SYSTEM   = 4'd10;
    localparam logic [3:0] OPC_ILLEGAL  = 4'd15;

    typedef struct packed {
        logic [3:0]  opclass;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    dec_t        dec;
    dec_t        out_q;
    logic [31:0] imm_i_t, imm_s_t, imm_b_t, imm_u_t, imm_j_t;
    logic        accept;
    logic        done;
    logic        load_out;

    assign imm_i_t = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_t = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_t = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_t = {instr_i[31:12], 12'h000};
    assign imm_j_t = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.rd      = instr_i[11:7];
        dec.rs1     = instr_i[19:15];
        dec.rs2     = instr_i[24:20];
        dec.funct3  = instr_i[14:12];
        dec.alt     = instr_i[30];
        case (instr_i[6:0])
            7'b0110111: begin dec.opclass = OPC_LUI;      dec.imm = imm_u_t; end
            7'b0010111: begin dec.opclass = OPC_AUIPC;    dec.imm = imm_u_t; end
            7'b1101111: begin dec.opclass = OPC_JAL;      dec.imm = imm_j_t; end
            7'b1100111: begin dec.opclass = OPC_JALR;     dec.imm = imm_i_t; end
            7'b1100011: begin dec.opclass = OPC_BRANCH;   dec.imm = imm_b_t; end
            7'b0000011: begin dec.opclass = OPC_LOAD;     dec.imm = imm_i_t; end
            7'b0100011: begin dec.opclass = OPC_STORE;    dec.imm = imm_s_t; end
            7'b0010011: begin dec.opclass = OPC_OP_IMM;   dec.imm = imm_i_t; end
            7'b0110011: begin dec.opclass = OPC_OP;       dec.imm = 32'h0;   end
            7'b0001111: begin dec.opclass = OPC_MISC_MEM; dec.imm = imm_i_t; end
            7'b1110011: begin dec.opclass = OPC_SYSTEM;   dec.imm = imm_i_t; end
            default: begin
                dec.opclass = OPC_ILLEGAL;
                dec.imm     = 32'h0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign accept = input_valid_i && input_ready_o;
    assign done   = output_valid_o && output_ready_i;

`ifdef ECAP5_DPROC_DECM_SKID_EN
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t state_q, state_d;
    dec_t   skid_q;
    logic   load_skid;
    logic   pop_skid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= dec;
            end else if (pop_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin state_d = FULL; load_out = 1'b1; end
            FULL: begin
                if (accept && !done) begin
                    state_d   = SKID;
                    load_skid = 1'b1;
                end else if (accept) begin
                    load_out = 1'b1;
                end else if (done) begin
                    state_d = EMPTY;
                end
            end
            SKID: if (done) begin state_d = FULL; pop_skid = 1'b1; end
            default: state_d = EMPTY;
        endcase
        // Flush wins: a beat accepted on the same edge is dropped.
        if (flush_i) begin
            state_d   = EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
            pop_skid  = 1'b0;
        end
    end

    assign input_ready_o  = (state_q != SKID);
`else
    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= dec;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin state_d = FULL; load_out = 1'b1; end
            FULL: begin
                if (accept) begin
                    load_out = 1'b1;
                end else if (done) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d  = EMPTY;
            load_out = 1'b0;
        end
    end

    assign input_ready_o  = (state_q == EMPTY) || output_ready_i;
`endif

    assign output_valid_o = (state_q != EMPTY);
    assign opclass_o      = out_q.opclass;
    assign rd_o           = out_q.rd;
    assign rs1_o          = out_q.rs1;
    assign rs2_o          = out_q.rs2;
    assign funct3_o       = out_q.funct3;
    assign alt_o          = out_q.alt;
    assign imm_o          = out_q.imm;
    assign illegal_o      = out_q.illegal;

endmodule
